multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I-subset controller.
- Fetches each instruction through a req/valid port, decodes it, and sequences the existing datapath across FETCH/EXEC/MEM states.
- Stalls on memory `busy`, resolves all six conditional branches plus JAL/JALR.
- Takes interrupts at instruction boundaries with a saved `sepc`, and supports CSRR of `sepc`.
- Sits between the instruction memory, the register-file/ALU datapath and the data memory or cache.

Parameters:
- NBITS, 8, datapath and PC width.
- NREGS, 32, register count; register index width is $clog2(NREGS).
- WIDTH_ALUF, 4, ALU function width; encoding is {funct7[5], funct3}: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- RESET_PC, 0, PC after reset.
- IRQ_VECTOR, 'h40, PC loaded on interrupt entry.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr_req  out  1  fetch request.
- instr_addr  out  NBITS  fetch address (= pc).
- instr_valid  in  1  instr_data valid this cycle.
- instr_data  in  32  fetched instruction.
- RS1, RS2, RD  out  $clog2(NREGS)  register indices.
- IMM  out  NBITS  sign-extended immediate, truncated to NBITS.
- ALUSrc  out  1  ALU operand B = IMM.
- ALUControl  out  WIDTH_ALUF  ALU function.
- MemtoReg  out  1  writeback from memory.
- RegWrite  out  1  register write strobe.
- link  out  1  write pclink to RD.
- pclink  out  NBITS  link or sepc value.
- Zero, Neg, Carry  in  1  ALU flags.
- PCReg  in  NBITS  RS1 value for JALR.
- MemRead, MemWrite  out  1  data memory strobes.
- busy  in  1  memory not ready.
- interrupt  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- pc  out  NBITS  current PC.
- sepc  out  NBITS  saved return PC.

Behaviour:

Reset:
- pc = RESET_PC; sepc = 0; state = FETCH.
- All strobes, indices, IMM, ALUControl and pclink are 0.
- Assertion mid-operation aborts immediately. No write or memory strobe may appear in the cycle after release.

FETCH:
- Drive instr_req=1 and instr_addr=pc.
- Hold until instr_valid=1, then latch instr_data into the instruction register and go to EXEC.
- Minimum fetch latency is 1 cycle.

EXEC:
- Decoded fields come from the latched instruction and are stable for the whole instruction: RS1=[19:15], RS2=[24:20], RD=[11:7], op=[6:2].
- Per opcode:
  - RType (01100): ALUControl={f7[5],f3}; RegWrite.
  - IType (00100): ALUSrc; ALUControl={f3==101 ? f7[5] : 0, f3}; RegWrite.
  - UType/LUI (01101): RS1 forced to 0, ALUSrc, ADD, RegWrite.
  - IJal (11011): link with pclink=pc+4; RegWrite; next pc = pc+IMM.
  - IJalr (11001): link with pclink=pc+4; RegWrite; next pc = (PCReg+IMM) & ~1.
  - SBType (11000): ALU does SUB. Branch is taken per f3: BEQ Zero, BNE !Zero, BLT Neg, BGE !Neg, BLTU !Carry, BGEU Carry. Taken: pc+IMM; not taken: pc+4. No RegWrite.
  - LType/SType: ALUSrc, ADD, go to MEM.
  - ICsrr (11100): link with pclink=sepc; RegWrite.
  - Other opcodes: illegal pulse, treated as NOP.
- RegWrite is suppressed when RD==0.
- Every non-memory instruction spends exactly 1 EXEC cycle, then returns to FETCH.

MEM:
- Assert MemRead (load) or MemWrite (store), held while busy=1.
- In the first cycle with busy=0: a load also asserts MemtoReg and RegWrite (suppressed when RD==0).
- pc becomes pc+4 and the state returns to FETCH.

Arithmetic:
- All PC arithmetic is modulo 2^NBITS; pc+4 wraps to 0.

Interrupts:
- interrupt is sampled only on the cycle an instruction retires (the transition to FETCH).
- If set: sepc <= computed next pc; pc <= IRQ_VECTOR; irq_ack pulses.
- interrupt is never taken during FETCH wait or a busy stall.
- Return from the handler is CSRR into a register followed by JALR.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs instret and stall_cycles, each 32 bits.
  - Both reset to 0.
  - instret increments on each retire.
  - stall_cycles increments on each cycle in FETCH with instr_valid=0, or in MEM with busy=1.
  - Both wrap at 2^32.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, instr_valid after 3 cycles with ADDI x1,x0,5 -> instr_addr=0; EXEC: ALUSrc=1, IMM=5, ALUControl=0000, RegWrite=1, RD=1; next fetch at pc=4.
- BLT with Neg=1 and IMM=-8 at pc=0x20 -> next pc=0x18. Same instruction with Neg=0 -> next pc=0x24.
- LW with busy=1 for 4 cycles -> MemRead held 5 cycles; RegWrite and MemtoReg asserted only in the final cycle; pc advances by 4.
- interrupt=1 during a busy stall of SW at pc=0x10 -> no entry until retire; then sepc=0x14, pc=0x40, irq_ack high for 1 cycle. A following CSRR x5 gives pclink=0x14 with link=1.
- JAL x0 at pc=0xFC with NBITS=8, IMM=8 -> pc=0x04 (wrap); RegWrite=0. Reset asserted while in MEM -> strobes drop the same cycle, pc=RESET_PC.
- With CTRL_PERF_CNT_EN: 3 instructions, one with a 2-cycle busy stall and fetches with 1-cycle valid latency -> instret=3, stall_cycles=2.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I-subset controller. Fetches each instruction over a
//   req/valid port, latches it, then sequences the register-file/ALU
//   datapath through FETCH -> EXEC (-> MEM) -> FETCH.
//   Resolves conditional branches, JAL and JALR. Takes level interrupts only
//   when an instruction retires, saving the return PC in sepc. CSRR reads
//   sepc back through pclink.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   instr_req/addr/valid/data instruction fetch handshake (addr = pc)
//   RS1, RS2, RD, IMM         decoded register indices and immediate
//   ALUSrc, ALUControl        ALU operand-B select and function
//   MemtoReg, RegWrite        writeback select and register write strobe
//   link, pclink              write pclink (pc+4 or sepc) into RD
//   Zero, Neg, Carry          ALU flags for branch resolution
//   PCReg                     RS1 value, JALR base
//   MemRead, MemWrite, busy   data memory strobes and stall input
//   interrupt, irq_ack        level request, one-cycle entry pulse
//   illegal                   one-cycle pulse on an unknown opcode
//   pc, sepc                  current PC and saved return PC
//
// Optional feature (macro CTRL_PERF_CNT_EN)
//   Adds 32-bit counters instret (retired instructions) and stall_cycles
//   (FETCH cycles without instr_valid plus MEM cycles with busy).

module multicycle_controller #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4,
    parameter int RESET_PC   = 0,
    parameter int IRQ_VECTOR = 'h40
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     instr_req,
    output logic [NBITS-1:0]         instr_addr,
    input  logic                     instr_valid,
    input  logic [31:0]              instr_data,
    output logic [$clog2(NREGS)-1:0] RS1,
    output logic [$clog2(NREGS)-1:0] RS2,
    output logic [$clog2(NREGS)-1:0] RD,
    output logic [NBITS-1:0]         IMM,
    output logic                     ALUSrc,
    output logic [WIDTH_ALUF-1:0]    ALUControl,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     link,
    output logic [NBITS-1:0]         pclink,
    input  logic                     Zero,
    input  logic                     Neg,
    input  logic                     Carry,
    input  logic [NBITS-1:0]         PCReg,
    output logic                     MemRead,
    output logic                     MemWrite,
    input  logic                     busy,
    input  logic                     interrupt,
    output logic                     irq_ack,
    output logic                     illegal,
    output logic [NBITS-1:0]         pc,
    output logic [NBITS-1:0]         sepc
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]              instret,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int RW = $clog2(NREGS);

    localparam logic [4:0] OP_R    = 5'b01100;
    localparam logic [4:0] OP_I    = 5'b00100;
    localparam logic [4:0] OP_LUI  = 5'b01101;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;
    localparam logic [4:0] OP_B    = 5'b11000;
    localparam logic [4:0] OP_L    = 5'b00000;
    localparam logic [4:0] OP_S    = 5'b01000;
    localparam logic [4:0] OP_CSR  = 5'b11100;

    // Reset value of the instruction register is ADD x0,x0,x0 so that every
    // decoded output (indices, IMM, ALUSrc, ALUControl, pclink) reads zero.
    localparam logic [31:0] IR_RESET = 32'h0000_0033;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_t;

    state_t           state;
    logic [31:0]      ir;
    logic             irq_ack_q;

    logic [4:0]       op;
    logic [2:0]       f3;
    logic             f7b5;
    logic [NBITS-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [3:0]       alu_f;
    logic             alu_src, wr_op, link_op, known, taken;
    logic             in_exec, in_mem, is_load, is_store, retire;
    logic [NBITS-1:0] pc4, next_pc;

    assign op   = ir[6:2];
    assign f3   = ir[14:12];
    assign f7b5 = ir[30];

    assign imm_i = NBITS'({{20{ir[31]}}, ir[31:20]});
    assign imm_s = NBITS'({{20{ir[31]}}, ir[31:25], ir[11:7]});
    assign imm_b = NBITS'({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
    assign imm_u = NBITS'({ir[31:12], 12'h000});
    assign imm_j = NBITS'({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});

    always_comb begin
        imm     = '0;
        alu_f   = 4'b0000;
        alu_src = 1'b0;
        wr_op   = 1'b0;
        link_op = 1'b0;
        known   = (ir[1:0] == 2'b11);
        case (op)
            OP_R:    begin alu_f = {f7b5, f3}; wr_op = 1'b1; end
            OP_I:    begin
                         alu_src = 1'b1;
                         alu_f   = {(f3 == 3'b101) & f7b5, f3};
                         imm     = imm_i;
                         wr_op   = 1'b1;
                     end
            OP_LUI:  begin alu_src = 1'b1; imm = imm_u; wr_op = 1'b1; end
            OP_JAL:  begin imm = imm_j; wr_op = 1'b1; link_op = 1'b1; end
            OP_JALR: begin imm = imm_i; wr_op = 1'b1; link_op = 1'b1; end
            OP_B:    begin alu_f = 4'b1000; imm = imm_b; end
            OP_L:    begin alu_src = 1'b1; imm = imm_i; end
            OP_S:    begin alu_src = 1'b1; imm = imm_s; end
            OP_CSR:  begin imm = imm_i; wr_op = 1'b1; link_op = 1'b1; end
            default: known = 1'b0;
        endcase
    end

    // Branch condition on the flags of the SUB the ALU is doing this cycle.
    always_comb begin
        case (f3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Neg;
            3'b101:  taken = !Neg;
            3'b110:  taken = !Carry;
            3'b111:  taken = Carry;
            default: taken = 1'b0;
        endcase
    end

    assign pc4 = pc + NBITS'(4);

    always_comb begin
        next_pc = pc4;
        case (op)
            OP_JAL:  next_pc = pc + imm;
            OP_JALR: next_pc = (PCReg + imm) & ~NBITS'(1);
            OP_B:    if (taken) next_pc = pc + imm;
            default: next_pc = pc4;
        endcase
    end

    assign in_exec  = (state == S_EXEC);
    assign in_mem   = (state == S_MEM);
    assign is_load  = (op == OP_L);
    assign is_store = (op == OP_S);
    assign retire   = (in_exec && !(is_load || is_store)) || (in_mem && !busy);

    // Strobes come from the registered state, so an async reset (which forces
    // FETCH) drops them in the same cycle.
    assign instr_req  = (state == S_FETCH) && !reset;
    assign instr_addr = pc;
    assign RS1        = (op == OP_LUI) ? '0 : ir[15 +: RW];
    assign RS2        = ir[20 +: RW];
    assign RD         = ir[7 +: RW];
    assign IMM        = imm;
    assign ALUSrc     = alu_src;
    assign ALUControl = WIDTH_ALUF'(alu_f);
    assign MemRead    = in_mem && is_load;
    assign MemWrite   = in_mem && is_store;
    assign MemtoReg   = in_mem && is_load && !busy;
    assign RegWrite   = (ir[11:7] != 5'd0) &&
                        ((in_exec && wr_op) || (in_mem && is_load && !busy));
    assign link       = in_exec && link_op;
    assign pclink     = link_op ? ((op == OP_CSR) ? sepc : pc4) : '0;
    assign illegal    = in_exec && !known;
    assign irq_ack    = irq_ack_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= IR_RESET;
            pc        <= NBITS'(RESET_PC);
            sepc      <= '0;
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= 1'b0;
            case (state)
                S_FETCH: if (instr_valid) begin
                             ir    <= instr_data;
                             state <= S_EXEC;
                         end
                S_EXEC:  state <= (is_load || is_store) ? S_MEM : S_FETCH;
                S_MEM:   if (!busy) state <= S_FETCH;
                default: state <= S_FETCH;
            endcase
            // Interrupts are only looked at on the retire edge.
            if (retire) begin
                if (interrupt) begin
                    sepc      <= next_pc;
                    pc        <= NBITS'(IRQ_VECTOR);
                    irq_ack_q <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret      <= '0;
            stall_cycles <= '0;
        end else begin
            if (retire) instret <= instret + 32'd1;
            if ((state == S_FETCH && !instr_valid) || (in_mem && busy))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (NBITS=8 defaults).
// An instruction-level reference model tracks pc, sepc, the irq_ack pulse
// and the performance counts; each instruction is applied with random fetch
// latency, busy stalls, flags and interrupt noise outside retire cycles.

module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_req, instr_valid;
    logic [7:0]  instr_addr;
    logic [31:0] instr_data;
    logic [4:0]  RS1, RS2, RD;
    logic [7:0]  IMM, pclink, PCReg, pc, sepc;
    logic        ALUSrc, MemtoReg, RegWrite, link, Zero, Neg, Carry;
    logic [3:0]  ALUControl;
    logic        MemRead, MemWrite, busy, interrupt, irq_ack, illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret, stall_cycles;
`endif

    multicycle_controller dut (
        .clock(clock), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
        .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .link(link), .pclink(pclink),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .PCReg(PCReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy),
        .interrupt(interrupt), .irq_ack(irq_ack), .illegal(illegal),
        .pc(pc), .sepc(sepc)
`ifdef CTRL_PERF_CNT_EN
        , .instret(instret), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LUI = 5'b01101;
    localparam logic [4:0] OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_B = 5'b11000;
    localparam logic [4:0] OP_L = 5'b00000, OP_S = 5'b01000, OP_CSR = 5'b11100;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0]  m_pc, m_sepc;
    bit          m_ack;
    int unsigned m_instret, m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_sepc = 8'h00; m_ack = 1'b0;
        m_instret = 0; m_stall = 0;
    endtask

    // One instruction: lat empty fetch cycles, bsy busy cycles in MEM, irq
    // held on the retire cycle only.
    task automatic run_instr(input logic [31:0] ins, input int lat, input int bsy,
                             input bit irq, input bit z, input bit n, input bit c,
                             input logic [7:0] pcreg);
        logic [4:0] op, rd;
        logic [2:0] f3;
        int         imm;
        logic [7:0] imm8, nxt, p4;
        bit         known, is_l, is_s, wr, lk, tk, dec_chk, src;
        logic [3:0] alu;

        for (int i = 0; i <= lat; i++) begin
            instr_valid = (i == lat);
            instr_data  = (i == lat) ? ins : $urandom;
            interrupt   = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("instr_req", instr_req, 1);
            chk("instr_addr", instr_addr, m_pc);
            chk("irq_ack", irq_ack, m_ack);
            chk("sepc", sepc, m_sepc);
            chk("fetch_strobes", {RegWrite, MemRead, MemWrite, MemtoReg, link, illegal}, 0);
            m_ack = 1'b0;
            if (i < lat) m_stall++;
            @(posedge clock); #1;
        end
        instr_valid = 1'b0;
        instr_data  = $urandom;

        op = ins[6:2]; f3 = ins[14:12]; rd = ins[11:7];
        known = 1; is_l = 0; is_s = 0; wr = 0; lk = 0; dec_chk = 1; src = 0; alu = 4'b0000;
        imm = 0;
        case (op)
            OP_R:    begin wr = 1; alu = {ins[30], f3}; end
            OP_I:    begin wr = 1; src = 1; imm = $signed(ins[31:20]);
                           alu = {(f3 == 3'b101) ? ins[30] : 1'b0, f3}; end
            OP_LUI:  begin wr = 1; src = 1; imm = $signed({ins[31:12], 12'h000}); end
            OP_JAL:  begin wr = 1; lk = 1; dec_chk = 0;
                           imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
            OP_JALR: begin wr = 1; lk = 1; dec_chk = 0; imm = $signed(ins[31:20]); end
            OP_B:    begin alu = 4'b1000;
                           imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
            OP_L:    begin is_l = 1; src = 1; imm = $signed(ins[31:20]); end
            OP_S:    begin is_s = 1; src = 1; imm = $signed({ins[31:25], ins[11:7]}); end
            OP_CSR:  begin wr = 1; lk = 1; dec_chk = 0; end
            default: begin known = 0; dec_chk = 0; end
        endcase
        imm8 = imm[7:0];
        p4   = m_pc + 8'd4;
        case (f3)
            3'b000: tk = z;
            3'b001: tk = !z;
            3'b100: tk = n;
            3'b101: tk = !n;
            3'b110: tk = !c;
            3'b111: tk = c;
            default: tk = 0;
        endcase
        if (op == OP_JAL)                nxt = m_pc + imm8;
        else if (op == OP_JALR)          nxt = (pcreg + imm8) & 8'hFE;
        else if (op == OP_B && tk)       nxt = m_pc + imm8;
        else                             nxt = p4;

        // EXEC
        Zero = z; Neg = n; Carry = c; PCReg = pcreg;
        interrupt = (is_l || is_s) ? 1'($urandom_range(0, 1)) : irq;
        @(negedge clock);
        chk("rs1", RS1, (op == OP_LUI) ? 5'd0 : ins[19:15]);
        chk("rs2", RS2, ins[24:20]);
        chk("rd", RD, rd);
        if (dec_chk) begin
            chk("alusrc", ALUSrc, src);
            chk("aluctl", ALUControl, alu);
            if (op != OP_R) chk("imm", IMM, imm8);
        end
        if (op == OP_JAL || op == OP_JALR) chk("imm_j", IMM, imm8);
        chk("regwrite_ex", RegWrite, wr && rd != 0);
        chk("link", link, lk);
        if (lk) chk("pclink", pclink, (op == OP_CSR) ? m_sepc : p4);
        chk("illegal", illegal, !known);
        chk("mem_ex", {MemRead, MemWrite}, 0);
        @(posedge clock); #1;

        // MEM
        if (is_l || is_s) begin
            for (int i = 0; i <= bsy; i++) begin
                busy      = (i < bsy);
                interrupt = (i < bsy) ? 1'($urandom_range(0, 1)) : irq;
                @(negedge clock);
                chk("memread", MemRead, is_l);
                chk("memwrite", MemWrite, is_s);
                chk("memtoreg", MemtoReg, is_l && i == bsy);
                chk("regwrite_mem", RegWrite, is_l && i == bsy && rd != 0);
                if (i < bsy) m_stall++;
                @(posedge clock); #1;
            end
            busy = 1'b0;
        end
        interrupt = 1'b0;

        m_instret++;
        if (irq) begin m_sepc = nxt; m_pc = 8'h40; m_ack = 1'b1; end
        else m_pc = nxt;
        chk("pc_retire", pc, m_pc);
    endtask

    task automatic goto_pc(input logic [7:0] target);
        run_instr(32'h0000_8067, 0, 0, 0, 0, 0, 0, target);  // JALR x0,0(x1)
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ops [12];
        logic [4:0]  op;
        logic [31:0] ins;

        ops = '{OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_B, OP_L, OP_S, OP_CSR,
                5'b00001, 5'b11111, 5'b10100};
        reset = 1'b1; instr_valid = 0; instr_data = 0; Zero = 0; Neg = 0; Carry = 0;
        PCReg = 0; busy = 0; interrupt = 0;
        model_reset();

        @(negedge clock);
        chk("rst_pc", pc, 0);
        chk("rst_sepc", sepc, 0);
        chk("rst_req", instr_req, 0);
        chk("rst_strobes", {RegWrite, MemRead, MemWrite, MemtoReg, link, illegal, irq_ack, ALUSrc}, 0);
        chk("rst_idx", {RS1, RS2, RD}, 0);
        chk("rst_imm", IMM, 0);
        chk("rst_aluctl", ALUControl, 0);
        chk("rst_pclink", pclink, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // ADDI x1,x0,5 after three empty fetch cycles
        run_instr(32'h0050_0093, 3, 0, 0, 0, 0, 0, 0);
        chk("addi_next", pc, 8'h04);

        // BLT -8 at 0x20, taken then not taken
        goto_pc(8'h20);
        run_instr(32'hFE20_CCE3, 0, 0, 0, 0, 1, 0, 0);
        chk("blt_taken", pc, 8'h18);
        goto_pc(8'h20);
        run_instr(32'hFE20_CCE3, 1, 0, 0, 0, 0, 0, 0);
        chk("blt_not_taken", pc, 8'h24);

        // LW x3 with four busy cycles
        run_instr(32'h0000_2183, 0, 4, 0, 0, 0, 0, 0);
        chk("lw_pc", pc, 8'h28);

        // SW at 0x10, interrupt pending through the stall and on retire
        goto_pc(8'h10);
        run_instr(32'h0020_2023, 0, 3, 1, 0, 0, 0, 0);
        chk("irq_pc", pc, 8'h40);
        chk("irq_sepc", sepc, 8'h14);
        run_instr(32'h1410_22F3, 0, 0, 0, 0, 0, 0, 0);  // CSRR x5, sepc

        // JAL x0,+8 at 0xFC wraps to 0x04
        goto_pc(8'hFC);
        run_instr(32'h0080_006F, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_wrap", pc, 8'h04);

        // reset while stalled in MEM
        instr_valid = 1; instr_data = 32'h0000_2183;
        @(posedge clock); #1;
        instr_valid = 0;
        @(posedge clock); #1;
        busy = 1;
        @(negedge clock);
        chk("mem_before_rst", MemRead, 1);
        reset = 1; #1;
        chk("rst_mid_strobes", {MemRead, MemWrite, RegWrite, MemtoReg}, 0);
        chk("rst_mid_pc", pc, 0);
        @(posedge clock); #1;
        reset = 0; busy = 0;
        model_reset();

`ifdef CTRL_PERF_CNT_EN
        run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0000_2183, 0, 2, 0, 0, 0, 0, 0);
        run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_instret", instret, 3);
        chk("perf_stall", stall_cycles, 2);
`endif

        for (int k = 0; k < 200; k++) begin
            op  = ops[$urandom_range(0, 11)];
            ins = $urandom;
            ins[6:0] = {op, 2'b11};
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
                      1'($urandom), 8'($urandom));
        end

`ifdef CTRL_PERF_CNT_EN
        chk("instret_final", instret, m_instret);
        chk("stall_final", stall_cycles, m_stall);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
